// File: rtl/wb_sram_arb2.sv
// Two-master Wishbone arbiter in front of a single SRAM slave port.
// Round-robin grant with cycle locking, plus a watchdog that ends a hung
// strobe with a one-cycle err to the owning master.
module wb_sram_arb2 #(
  parameter int WB_ADDRESS_WIDTH = 32,
  parameter int WB_DATA_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                          clk,
  input  logic                          rstn,
  // master 0
  input  logic [WB_ADDRESS_WIDTH-1:0]   m0_adr,
  input  logic [WB_DATA_WIDTH-1:0]      m0_dat_w,
  output logic [WB_DATA_WIDTH-1:0]      m0_dat_r,
  input  logic                          m0_cyc,
  input  logic                          m0_stb,
  input  logic                          m0_we,
  input  logic [WB_DATA_WIDTH/8-1:0]    m0_sel,
  output logic                          m0_ack,
  output logic                          m0_err,
  // master 1
  input  logic [WB_ADDRESS_WIDTH-1:0]   m1_adr,
  input  logic [WB_DATA_WIDTH-1:0]      m1_dat_w,
  output logic [WB_DATA_WIDTH-1:0]      m1_dat_r,
  input  logic                          m1_cyc,
  input  logic                          m1_stb,
  input  logic                          m1_we,
  input  logic [WB_DATA_WIDTH/8-1:0]    m1_sel,
  output logic                          m1_ack,
  output logic                          m1_err,
  // slave
  output logic [WB_ADDRESS_WIDTH-1:0]   s_adr,
  output logic [WB_DATA_WIDTH-1:0]      s_dat_w,
  input  logic [WB_DATA_WIDTH-1:0]      s_dat_r,
  output logic                          s_cyc,
  output logic                          s_stb,
  output logic                          s_we,
  output logic [WB_DATA_WIDTH/8-1:0]    s_sel,
  input  logic                          s_ack,
  input  logic                          s_err
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state_q, state_d;
  logic            last_gnt_q, last_gnt_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;
  logic            own_stb;

  // Grant decision: IDLE picks a requester (the one not granted last on a tie),
  // an owner keeps the slave until it drops cyc, then one IDLE cycle follows.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc && (!m1_cyc || last_gnt_q)) begin
          state_d    = OWN0;
          last_gnt_d = 1'b0;
        end else if (m1_cyc) begin
          state_d    = OWN1;
          last_gnt_d = 1'b1;
        end
      end
      OWN0:    if (!m0_cyc) state_d = IDLE;
      OWN1:    if (!m1_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slave-side mux: the owner's request goes through, IDLE parks on m0 with cyc/stb low.
  always_comb begin
    s_adr   = m0_adr;
    s_dat_w = m0_dat_w;
    s_we    = m0_we;
    s_sel   = m0_sel;
    s_cyc   = 1'b0;
    own_stb = 1'b0;
    if (state_q == OWN1) begin
      s_adr   = m1_adr;
      s_dat_w = m1_dat_w;
      s_we    = m1_we;
      s_sel   = m1_sel;
      s_cyc   = m1_cyc;
      own_stb = m1_stb;
    end else if (state_q == OWN0) begin
      s_cyc   = m0_cyc;
      own_stb = m0_stb;
    end
  end

  // The timeout cycle masks the strobe so a late slave ack cannot complete anything.
  assign s_stb = own_stb & ~timeout_q;

  // Responses reach only the owner; the watchdog's err replaces any slave ack.
  always_comb begin
    m0_ack = (state_q == OWN0) & s_ack & ~timeout_q;
    m0_err = (state_q == OWN0) & (s_err | timeout_q);
    m1_ack = (state_q == OWN1) & s_ack & ~timeout_q;
    m1_err = (state_q == OWN1) & (s_err | timeout_q);
  end

  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

  // Watchdog: count unanswered strobe cycles; any answer, idle strobe or ownership change restarts it.
  always_comb begin
    wd_cnt_d  = '0;
    timeout_d = 1'b0;
    if (WD_EN && (state_d == state_q) && s_stb && !s_ack && !s_err) begin
      if (wd_cnt_q == WD_LAST) timeout_d = 1'b1;
      else                     wd_cnt_d  = wd_cnt_q + WD_W'(1);
    end
  end

  // State registers; last_gnt resets to 1 so m0 wins the first contention.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      wd_cnt_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      wd_cnt_q   <= wd_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_wb_sram_arb2.sv
// Bench for wb_sram_arb2: random traffic from two masters into an SRAM model,
// a scoreboard fed at issue time and a monitor that checks every ack/err.
module tb_wb_sram_arb2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
  localparam int WORDS = 512;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic [AW-1:0] m0_adr = '0, m1_adr = '0;
  logic [DW-1:0] m0_dat_w = '0, m1_dat_w = '0;
  logic [DW-1:0] m0_dat_r, m1_dat_r;
  logic m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [SW-1:0] m0_sel = '0, m1_sel = '0;
  logic m0_ack, m0_err, m1_ack, m1_err;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_w;
  logic [DW-1:0] s_dat_r;
  logic s_cyc, s_stb, s_we;
  logic [SW-1:0] s_sel;
  logic s_ack;
  logic s_err = 1'b0;

  always #5 clk = ~clk;

  wb_sram_arb2 #(
    .WB_ADDRESS_WIDTH(AW),
    .WB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_ack(s_ack), .s_err(s_err)
  );

  typedef struct {
    logic          err;
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  int checks = 0;
  int failures = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int done_order[$];
  int exp_order[$];
  int ack_cnt[2];
  int err_cnt[2];
  logic [DW-1:0] last_rd[2];
  logic [DW-1:0] ref_mem [WORDS];
  logic [DW-1:0] slv_mem [WORDS];
  bit slave_hang = 1'b0;
  int wait_cnt;

  // Compare one observed value against the bench's own expectation.
  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Byte-lane merge used by both the SRAM model and the reference memory.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [SW-1:0] sel);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < SW; b++)
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // SRAM slave model: registered ack after 0..3 random wait states, or never when hung.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_ack    <= 1'b0;
      s_dat_r  <= '0;
      wait_cnt <= 0;
      for (int i = 0; i < WORDS; i++) slv_mem[i] <= '0;
    end else begin
      s_ack <= 1'b0;
      if (s_cyc && s_stb && !s_ack && !slave_hang) begin
        if (wait_cnt == 0) begin
          s_ack <= 1'b1;
          if (s_we) slv_mem[s_adr[10:2]] <= merge(slv_mem[s_adr[10:2]], s_dat_w, s_sel);
          else      s_dat_r <= slv_mem[s_adr[10:2]];
          wait_cnt <= int'($urandom_range(0, 3));
        end else begin
          wait_cnt <= wait_cnt - 1;
        end
      end
    end
  end

  // Pop the oldest expectation for a master and compare it with what the DUT returned.
  task automatic score(input int n, input logic ack, input logic err, input logic [DW-1:0] d);
    exp_t e;
    int depth;
    depth = (n == 0) ? exp_q0.size() : exp_q1.size();
    if (depth == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_resp_m%0d: got ack=%0b err=%0b, expected no response", n, ack, err);
    end else begin
      e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check_output($sformatf("resp_err_m%0d", n), 64'(err), 64'(e.err));
      if (!e.err && e.rd) check_output($sformatf("rd_data_m%0d", n), 64'(d), 64'(e.data));
      if (e.rd) last_rd[n] = d;
    end
    if (ack) begin
      ack_cnt[n]++;
      done_order.push_back(n);
    end
    if (err) err_cnt[n]++;
  endtask

  // Monitor: every ack/err seen mid-cycle is matched against the scoreboard.
  always @(negedge clk) begin
    if (m0_ack || m0_err) score(0, m0_ack, m0_err, m0_dat_r);
    if (m1_ack || m1_err) score(1, m1_ack, m1_err, m1_dat_r);
  end

  task automatic drive(input int n, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    if (n == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat_w = dat; m0_sel = sel;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat_w = dat; m1_sel = sel;
    end
  endtask

  task automatic drive_ctl(input int n, input logic cyc, input logic stb);
    if (n == 0) begin m0_cyc = cyc; m0_stb = stb; end
    else        begin m1_cyc = cyc; m1_stb = stb; end
  endtask

  // One classic Wishbone access from master n; the expectation is queued before driving.
  task automatic apply_stimulus(input int n, input logic we, input logic [AW-1:0] adr,
                                input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                                input bit keep_cyc, input bit exp_err);
    exp_t e;
    bit done;
    int idx;
    idx    = int'(adr[10:2]);
    done   = 1'b0;
    e.err  = exp_err;
    e.rd   = !we;
    e.data = ref_mem[idx];
    if (we && !exp_err) ref_mem[idx] = merge(ref_mem[idx], dat, sel);
    if (n == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    drive(n, 1'b1, 1'b1, we, adr, dat, sel);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if ((n == 0) ? (m0_ack || m0_err) : (m1_ack || m1_err)) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL no_response_m%0d: got nothing in 100 cycles, expected ack or err", n);
    end
    @(posedge clk); #1;
    drive_ctl(n, keep_cyc, 1'b0);
  endtask

  task automatic clear_ref();
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    clear_ref();
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  // Compare the completion order against exp_order.
  task automatic check_order(input string tag);
    check_output({tag, "_count"}, 64'(done_order.size()), 64'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < done_order.size(); i++)
      check_output($sformatf("%s_%0d", tag, i), 64'(done_order[i]), 64'(exp_order[i]));
  endtask

  task automatic rand_xfer(input int n);
    logic [AW-1:0] base;
    base = (n == 0) ? 32'h0 : 32'h100;
    apply_stimulus(n, 1'($urandom_range(0, 1)), base + AW'($urandom_range(0, 63) * 4),
                   DW'($urandom), SW'($urandom_range(1, 15)), 1'b0, 1'b0);
  endtask

  // Global time bound so the bench always reaches its summary.
  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL global_timeout: got no end of test, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int a0, e0;
    clear_ref();
    // reset holds IDLE even with m0 requesting
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0, '0, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_s_cyc", 64'(s_cyc), 64'd0);
    check_output("reset_s_stb", 64'(s_stb), 64'd0);
    check_output("reset_m0_ack", 64'(m0_ack), 64'd0);
    check_output("reset_m0_err", 64'(m0_err), 64'd0);
    check_output("reset_m1_ack", 64'(m1_ack), 64'd0);
    reset_dut();

    // single write with 1-cycle arbitration latency, then read-back
    a0 = ack_cnt[0];
    fork
      apply_stimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
      begin
        @(negedge clk); check_output("arb_latency_t0", 64'(s_cyc), 64'd0);
        @(negedge clk); check_output("arb_latency_t1", 64'(s_cyc), 64'd1);
      end
    join
    check_output("single_ack_count", 64'(ack_cnt[0] - a0), 64'd1);
    @(posedge clk); #1;
    apply_stimulus(0, 1'b0, 32'h10, '0, 4'hF, 1'b0, 1'b0);
    check_output("readback_0x10", 64'(last_rd[0]), 64'hDEADBEEF);
    @(posedge clk); #1;

    // simultaneous request after reset: m0 burst first, one idle cycle, then m1
    reset_dut();
    done_order.delete();
    fork
      begin
        apply_stimulus(0, 1'b1, 32'h40, 32'hA5A5_0001, 4'hF, 1'b1, 1'b0);
        apply_stimulus(0, 1'b0, 32'h40, '0, 4'hF, 1'b0, 1'b0);
      end
      apply_stimulus(1, 1'b0, 32'h104, '0, 4'hF, 1'b0, 1'b0);
      begin
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (!m0_cyc) begin seen = 1'b1; break; end
        end
        check_output("handover_m0_drop_seen", 64'(seen), 64'd1);
        check_output("handover_drop_s_cyc", 64'(s_cyc), 64'd0);
        @(negedge clk);
        check_output("handover_idle_s_cyc", 64'(s_cyc), 64'd0);
        check_output("handover_idle_m1_ack", 64'(m1_ack), 64'd0);
        @(negedge clk);
        check_output("handover_grant_s_cyc", 64'(s_cyc), 64'd1);
      end
    join
    exp_order = {0, 0, 1};
    check_order("contention_order");
    @(posedge clk); #1;

    // continuous re-requests from both masters alternate strictly
    reset_dut();
    done_order.delete();
    fork
      for (int i = 0; i < 8; i++) begin rand_xfer(0); @(posedge clk); #1; end
      for (int i = 0; i < 8; i++) begin rand_xfer(1); @(posedge clk); #1; end
    join
    exp_order.delete();
    for (int i = 0; i < 16; i++) exp_order.push_back(i % 2);
    check_order("rr_order");

    // m1 locked burst of 4 beats holds off m0, which is served afterwards
    done_order.delete();
    fork
      for (int b = 0; b < 4; b++)
        apply_stimulus(1, 1'($urandom_range(0, 1)), 32'h180 + AW'(b * 4), DW'($urandom), 4'hF, b < 3, 1'b0);
      begin
        @(posedge clk); #1;
        rand_xfer(0);
      end
    join
    exp_order = {1, 1, 1, 1, 0};
    check_order("burst_order");
    @(posedge clk); #1;

    // watchdog: hung slave, m0 gets err exactly once, 9 cycles after its request
    slave_hang = 1'b1;
    done_order.delete();
    e0 = err_cnt[0];
    fork
      apply_stimulus(0, 1'b0, 32'h20, '0, 4'hF, 1'b0, 1'b1);
      begin
        repeat (2) @(posedge clk); #1;
        apply_stimulus(1, 1'b0, 32'h120, '0, 4'hF, 1'b0, 1'b0);
      end
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (k == 9) begin
          check_output("wd_err_cycle", 64'(m0_err), 64'd1);
          check_output("wd_stb_masked", 64'(s_stb), 64'd0);
          check_output("wd_no_ack", 64'(m0_ack), 64'd0);
          check_output("wd_m1_err", 64'(m1_err), 64'd0);
          slave_hang = 1'b0;
        end else if (k < 9 || k == 10) begin
          check_output($sformatf("wd_quiet_%0d", k), 64'(m0_err), 64'd0);
          if (k >= 1 && k <= 8) check_output($sformatf("wd_stb_%0d", k), 64'(s_stb), 64'd1);
        end
      end
    join
    check_output("wd_err_count", 64'(err_cnt[0] - e0), 64'd1);
    exp_order = {1};
    check_order("wd_order");
    @(posedge clk); #1;

    // asynchronous reset in the middle of an m1 write, then m0 wins contention
    slave_hang = 1'b1;
    drive(1, 1'b1, 1'b1, 1'b1, 32'h140, 32'h1234_5678, 4'hF);
    repeat (3) @(negedge clk);
    check_output("mid_write_s_cyc", 64'(s_cyc), 64'd1);
    check_output("mid_write_s_stb", 64'(s_stb), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check_output("async_reset_s_cyc", 64'(s_cyc), 64'd0);
    check_output("async_reset_s_stb", 64'(s_stb), 64'd0);
    clear_ref();
    slave_hang = 1'b0;
    done_order.delete();
    @(posedge clk); #1;
    fork
      apply_stimulus(0, 1'b0, 32'h30, '0, 4'hF, 1'b0, 1'b0);
      apply_stimulus(1, 1'b0, 32'h140, '0, 4'hF, 1'b0, 1'b0);
      begin
        repeat (2) @(negedge clk);
        rstn = 1'b1;
      end
    join
    exp_order = {0, 1};
    check_order("post_reset_order");

    repeat (3) @(posedge clk);
    check_output("scoreboard_empty_m0", 64'(exp_q0.size()), 64'd0);
    check_output("scoreboard_empty_m1", 64'(exp_q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
